ssd1306_spi_sink: RTL and testbench

Receive-side model of the SSD1306 4-wire SPI display port. It oversamples SCLK, MOSI, D/C#, CS# and RES# from an SSD1306 driver in the system clock domain, assembles bytes, and decodes the command/data stream. Display data bytes become framebuffer writes using horizontal-addressing column/page pointers. The block serves as the bench and loopback target for the display driver, and as the front end of an on-FPGA display mirror.

---
 rtl/ssd1306_spi_sink.sv | 210 +++++++++++++++++++++
 tb/tb_ssd1306_spi_sink.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_spi_sink.sv
// Receive-side model of the SSD1306 4-wire SPI port: byte assembly, command decode, framebuffer writes.
// Optional sticky partial-byte detection is built when SSD1306_SINK_FRAME_ERR_EN is defined.
module ssd1306_spi_sink #(
    parameter int FB_AW = 10
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_D0,
    input  logic             i_D1,
    input  logic             i_DC,
    input  logic             i_CS,
    input  logic             i_RES,
    output logic [7:0]       o_Byte,
    output logic             o_Byte_DV,
    output logic             o_Is_Data,
    output logic             o_FB_Wr_En,
    output logic [FB_AW-1:0] o_FB_Addr,
    output logic [7:0]       o_FB_Wr_Data,
    output logic             o_Display_On,
    output logic             o_Frame_Err
);

    typedef enum logic [2:0] {
        ST_CMD    = 3'd0,
        ST_COL_S  = 3'd1,
        ST_COL_E  = 3'd2,
        ST_PAGE_S = 3'd3,
        ST_PAGE_E = 3'd4
    } state_t;

    logic [2:0] sclk_sr_r;
    logic [1:0] mosi_sr_r;
    logic [1:0] dc_sr_r;
    logic [1:0] cs_sr_r;
    logic [1:0] res_sr_r;
    logic       rise_r;
    logic       cs_q_r;
    logic [7:0] shift_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] byte_r;
    logic       dc_r;
    logic       done_r;

    state_t     state_r;
    logic [6:0] col_r, col_start_r, col_end_r;
    logic [2:0] page_r, page_start_r, page_end_r;

    logic       soft_rst_s;
    logic       shift_en_s;

    // cs_q_r delays synced CS so it lines up with the registered rise pulse
    assign soft_rst_s = ~res_sr_r[1];
    assign shift_en_s = rise_r & ~cs_q_r;

    // Synchronisers, edge detect and byte assembly
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sclk_sr_r <= 3'b000;
            mosi_sr_r <= 2'b00;
            dc_sr_r   <= 2'b00;
            cs_sr_r   <= 2'b11;
            res_sr_r  <= 2'b11;
            rise_r    <= 1'b0;
            cs_q_r    <= 1'b1;
            shift_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
            byte_r    <= 8'h00;
            dc_r      <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            sclk_sr_r <= {sclk_sr_r[1:0], i_D0};
            mosi_sr_r <= {mosi_sr_r[0], i_D1};
            dc_sr_r   <= {dc_sr_r[0], i_DC};
            cs_sr_r   <= {cs_sr_r[0], i_CS};
            res_sr_r  <= {res_sr_r[0], i_RES};
            rise_r    <= sclk_sr_r[1] & ~sclk_sr_r[2];
            cs_q_r    <= cs_sr_r[1];
            done_r    <= 1'b0;
            if (soft_rst_s) begin
                shift_r   <= 8'h00;
                bit_cnt_r <= 3'd0;
            end else if (shift_en_s) begin
                shift_r   <= {shift_r[6:0], mosi_sr_r[1]};
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    byte_r <= {shift_r[6:0], mosi_sr_r[1]};
                    dc_r   <= dc_sr_r[1];
                    done_r <= 1'b1;
                end else begin
                    byte_r <= byte_r;
                end
            end else if (cs_sr_r[1]) begin
                shift_r   <= 8'h00;
                bit_cnt_r <= 3'd0;
            end else begin
                shift_r   <= shift_r;
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

`ifdef SSD1306_SINK_FRAME_ERR_EN
    logic frame_err_r;
    logic cs_rise_s;
    logic complete_s;

    assign cs_rise_s   = cs_sr_r[1] & ~cs_q_r;
    assign complete_s  = shift_en_s & (bit_cnt_r == 3'd7);
    assign o_Frame_Err = frame_err_r;

    // Sticky flag: CS released while a byte is only partly shifted in
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            frame_err_r <= 1'b0;
        end else if (soft_rst_s) begin
            frame_err_r <= 1'b0;
        end else if (cs_rise_s && (bit_cnt_r != 3'd0) && !complete_s) begin
            frame_err_r <= 1'b1;
        end else begin
            frame_err_r <= frame_err_r;
        end
    end
`else
    assign o_Frame_Err = 1'b0;
`endif

    // Command/data decoder, window pointers and registered outputs
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_r      <= ST_CMD;
            col_r        <= 7'd0;
            col_start_r  <= 7'd0;
            col_end_r    <= 7'd127;
            page_r       <= 3'd0;
            page_start_r <= 3'd0;
            page_end_r   <= 3'd7;
            o_Byte       <= 8'h00;
            o_Byte_DV    <= 1'b0;
            o_Is_Data    <= 1'b0;
            o_FB_Wr_En   <= 1'b0;
            o_FB_Addr    <= '0;
            o_FB_Wr_Data <= 8'h00;
            o_Display_On <= 1'b0;
        end else begin
            o_Byte_DV  <= 1'b0;
            o_FB_Wr_En <= 1'b0;
            if (soft_rst_s) begin
                state_r      <= ST_CMD;
                col_r        <= 7'd0;
                col_start_r  <= 7'd0;
                col_end_r    <= 7'd127;
                page_r       <= 3'd0;
                page_start_r <= 3'd0;
                page_end_r   <= 3'd7;
                o_Display_On <= 1'b0;
            end else if (done_r) begin
                o_Byte    <= byte_r;
                o_Is_Data <= dc_r;
                o_Byte_DV <= 1'b1;
                if (dc_r) begin
                    // Data aborts any pending argument and is written at the current pointers
                    state_r      <= ST_CMD;
                    o_FB_Wr_En   <= 1'b1;
                    o_FB_Addr    <= {page_r, col_r};
                    o_FB_Wr_Data <= byte_r;
                    if (col_r == col_end_r) begin
                        col_r  <= col_start_r;
                        page_r <= (page_r == page_end_r) ? page_start_r : page_r + 3'd1;
                    end else begin
                        col_r <= col_r + 7'd1;
                    end
                end else begin
                    case (state_r)
                        ST_CMD: begin
                            case (byte_r)
                                8'hAE:   o_Display_On <= 1'b0;
                                8'hAF:   o_Display_On <= 1'b1;
                                8'h21:   state_r <= ST_COL_S;
                                8'h22:   state_r <= ST_PAGE_S;
                                default: state_r <= ST_CMD;
                            endcase
                        end
                        ST_COL_S: begin
                            col_start_r <= byte_r[6:0];
                            col_r       <= byte_r[6:0];
                            state_r     <= ST_COL_E;
                        end
                        ST_COL_E: begin
                            col_end_r <= byte_r[6:0];
                            state_r   <= ST_CMD;
                        end
                        ST_PAGE_S: begin
                            page_start_r <= byte_r[2:0];
                            page_r       <= byte_r[2:0];
                            state_r      <= ST_PAGE_E;
                        end
                        ST_PAGE_E: begin
                            page_end_r <= byte_r[2:0];
                            state_r    <= ST_CMD;
                        end
                        default: state_r <= ST_CMD;
                    endcase
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// Self-checking bench for ssd1306_spi_sink: directed plan steps plus randomized traffic vs a behavioural model.
module tb_ssd1306_spi_sink;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0, mosi = 1'b0, dc = 1'b0, cs = 1'b1, res = 1'b1;
    logic [7:0] o_byte;
    logic       o_dv, o_isd, o_we, o_disp, o_ferr;
    logic [9:0] o_addr;
    logic [7:0] o_wd;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stray = 0;
    int last_rise = 0;
    logic [9:0] last_addr;

    // behavioural model of the decoder
    int m_st = 0, m_col = 0, m_cs = 0, m_ce = 127, m_page = 0, m_ps = 0, m_pe = 7, m_disp = 0;

`ifdef SSD1306_SINK_FRAME_ERR_EN
    localparam logic FE_EXP = 1'b1;
`else
    localparam logic FE_EXP = 1'b0;
`endif

    typedef struct {
        logic [7:0] b;
        logic       d;
        logic       w;
        logic [9:0] a;
        logic [7:0] wd;
        int         c;
    } ev_t;
    ev_t evq[$];

    ssd1306_spi_sink #(.FB_AW(10)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_D0(sclk), .i_D1(mosi), .i_DC(dc), .i_CS(cs), .i_RES(res),
        .o_Byte(o_byte), .o_Byte_DV(o_dv), .o_Is_Data(o_isd), .o_FB_Wr_En(o_we),
        .o_FB_Addr(o_addr), .o_FB_Wr_Data(o_wd), .o_Display_On(o_disp), .o_Frame_Err(o_ferr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_dv) evq.push_back('{o_byte, o_isd, o_we, o_addr, o_wd, cyc});
        if (o_we && !o_dv) stray++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic d);
        cs = 1'b0;
        dc = d;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            @(negedge clk);
            last_rise = cyc;
            repeat (3) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic model_byte(input logic [7:0] b, input logic d, output int exp_addr, output bit exp_w);
        exp_w = d;
        exp_addr = m_page * 128 + m_col;
        if (d) begin
            m_st = 0;
            if (m_col == m_ce) begin
                m_col = m_cs;
                m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
            end else begin
                m_col = (m_col + 1) % 128;
            end
        end else if (m_st == 1) begin
            m_cs = b % 128; m_col = m_cs; m_st = 2;
        end else if (m_st == 2) begin
            m_ce = b % 128; m_st = 0;
        end else if (m_st == 3) begin
            m_ps = b % 8; m_page = m_ps; m_st = 4;
        end else if (m_st == 4) begin
            m_pe = b % 8; m_st = 0;
        end else if (b == 8'hAE) m_disp = 0;
        else if (b == 8'hAF) m_disp = 1;
        else if (b == 8'h21) m_st = 1;
        else if (b == 8'h22) m_st = 3;
    endtask

    task automatic xfer(input logic [7:0] b, input logic d);
        int  ea;
        bit  ew;
        int  waited;
        ev_t e;
        send_bits(b, 8, d);
        model_byte(b, d, ea, ew);
        waited = 0;
        while (evq.size() == 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (evq.size() == 0) begin
            chk("dv_timeout", 32'd0, 32'd1);
        end else begin
            e = evq.pop_front();
            chk("byte", e.b, b);
            chk("is_data", e.d, d);
            chk("wr_en", e.w, ew);
            chk("latency", e.c, last_rise + 4);
            if (ew) begin
                chk("addr", e.a, ea);
                chk("wr_data", e.wd, b);
                last_addr = e.a;
            end
            chk("display_on", o_disp, m_disp);
        end
    endtask

    task automatic model_soft_reset();
        m_st = 0; m_col = 0; m_cs = 0; m_ce = 127; m_page = 0; m_ps = 0; m_pe = 7; m_disp = 0;
    endtask

    int plan_addr[8] = '{6*128+2, 6*128+3, 6*128+4, 7*128+2, 7*128+3, 7*128+4, 6*128+2, 6*128+3};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_byte", o_byte, 8'h00);
        chk("rst_dv", o_dv, 1'b0);
        chk("rst_isd", o_isd, 1'b0);
        chk("rst_we", o_we, 1'b0);
        chk("rst_addr", o_addr, 10'd0);
        chk("rst_wd", o_wd, 8'h00);
        chk("rst_disp", o_disp, 1'b0);
        chk("rst_ferr", o_ferr, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // display on/off commands
        xfer(8'hAF, 1'b0);
        chk("disp_on", o_disp, 1'b1);
        xfer(8'hAE, 1'b0);
        chk("disp_off", o_disp, 1'b0);

        // windowed horizontal addressing
        xfer(8'h21, 1'b0); xfer(8'h02, 1'b0); xfer(8'h04, 1'b0);
        xfer(8'h22, 1'b0); xfer(8'h06, 1'b0); xfer(8'h07, 1'b0);
        for (int i = 0; i < 8; i++) begin
            xfer(8'h10 + i[7:0], 1'b1);
            chk("plan_addr", last_addr, plan_addr[i]);
        end

        // partial byte then a full byte after restoring the default window
        res = 1'b0; repeat (6) @(negedge clk); res = 1'b1; repeat (6) @(negedge clk);
        model_soft_reset();
        send_bits(8'hFF, 5, 1'b1);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        chk("partial_none", evq.size(), 0);
        chk("frame_err", o_ferr, FE_EXP);
        xfer(8'hA5, 1'b1);
        chk("a5_addr", last_addr, 10'd0);

        // long run through the default window, then soft reset
        for (int i = 0; i < 129; i++) xfer(8'($urandom), 1'b1);
        xfer(8'hAF, 1'b0);
        res = 1'b0; repeat (6) @(negedge clk); res = 1'b1; repeat (6) @(negedge clk);
        model_soft_reset();
        chk("sres_disp", o_disp, 1'b0);
        chk("sres_ferr", o_ferr, 1'b0);
        xfer(8'h3C, 1'b1);
        chk("sres_addr", last_addr, 10'd0);

        // argument aborted by a data byte
        res = 1'b0; repeat (6) @(negedge clk); res = 1'b1; repeat (6) @(negedge clk);
        model_soft_reset();
        xfer(8'h21, 1'b0);
        xfer(8'h55, 1'b1);
        chk("abort_addr", last_addr, 10'd0);
        xfer(8'h66, 1'b1);
        chk("abort_next", last_addr, 10'd1);

        // randomized command/data traffic
        for (int n = 0; n < 70; n++) begin
            int r;
            r = $urandom_range(0, 9);
            case (r)
                0: xfer(8'hAE, 1'b0);
                1: xfer(8'hAF, 1'b0);
                2, 3: begin
                    xfer(r == 2 ? 8'h21 : 8'h22, 1'b0);
                    xfer(8'($urandom), ($urandom_range(0, 7) == 0));
                    xfer(8'($urandom), ($urandom_range(0, 7) == 0));
                end
                4: xfer(8'($urandom), 1'b0);
                default: xfer(8'($urandom), 1'b1);
            endcase
        end

        repeat (10) @(negedge clk);
        chk("stray_writes", stray, 0);
        chk("leftover_events", evq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
